inject_loader: RTL
==================

# inject_loader

Front-end sequencer for the systolic array input path. It accepts a serial element stream for one tile: 32 A-row vectors, then 32 B-column vectors. It assembles each vector into a parallel line and loads it into the matching row or column staggering FIFO with a one-hot load strobe. It then asserts the shared read enable for exactly DEPTH cycles so all FIFOs drain into the array together, and reports completion.

## Interface
- DIM, 32, array dimension; number of row FIFOs and number of column FIFOs
- DATA_W, 16, element width
- DEPTH, 64, FIFO depth; number of read_en cycles per tile
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  begin a tile; sampled only in IDLE
- in_valid  in  1  element stream valid
- in_ready  out  1  element stream ready
- in_data  in  DATA_W  element
- line_data  out  DATA_W x [0:DIM-1]  parallel line, shared by every FIFO data_in
- row_load  out  DIM  one-hot load strobe, row FIFO i
- col_load  out  DIM  one-hot load strobe, column FIFO j
- read_en  out  1  shared read enable to all FIFOs
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at tile end

## Operation
- FSM states: IDLE, FILL, LOAD, STREAM, DONE.
- Counters:
  - elem_idx, $clog2(DIM) bits
  - line_idx, $clog2(2*DIM) bits
  - rd_cnt, $clog2(DEPTH) bits
  - All counters are unsigned and never wrap within a tile.
- IDLE: in_ready=0, all strobes 0. start=1 -> FILL; clear elem_idx and line_idx.
- FILL:
  - in_ready=1. On in_valid&&in_ready: line_data[elem_idx] <= in_data; elem_idx++.
  - Acceptance with elem_idx==DIM-1 -> LOAD, with elem_idx cleared.
  - in_valid=0 stalls indefinitely with no state change.
- LOAD: one cycle.
  - in_ready=0.
  - If line_idx<DIM, row_load[line_idx]=1; otherwise col_load[line_idx-DIM]=1.
  - line_data is stable for this whole cycle.
  - If line_idx==2*DIM-1 -> STREAM with rd_cnt=0; otherwise line_idx++ -> FILL.
- STREAM: read_en=1 every cycle; rd_cnt++. When rd_cnt==DEPTH-1 -> DONE.
- DONE: done=1 for one cycle -> IDLE.
- Stream order:
  - Line L = 0..2*DIM-1; element k = 0..DIM-1 within each line.
  - Lines 0..DIM-1 are A rows; lines DIM..2*DIM-1 are B columns.
  - Element k of a line lands in line_data[k].
- line_data is never cleared between lines. Each element is overwritten in place.
- All outputs decode from registered state and registers only. There is no combinational path from any input to any output.
- start outside IDLE is ignored, including start asserted in the DONE cycle.
- in_valid outside FILL is ignored; no data is consumed.
- At most one bit of row_load|col_load is high in any cycle. No load strobe is ever high in the same cycle as read_en.

## Timing
- Reset values: state IDLE, counters 0, line_data all 0.
- Reset outputs: in_ready, row_load, col_load, read_en, busy and done are all 0.
- Reset assertion mid-tile forces IDLE asynchronously, and strobes drop immediately. FIFOs keep partial contents; the system resets them on the same rst_n.
- Cycle numbering with start sampled in cycle 0 and in_valid held high:
  - FILL of line 0 occupies cycles 1..32; its LOAD is cycle 33.
  - The LOAD for line L is cycle 33*(L+1). The last LOAD is cycle 2112.
  - read_en is high in cycles 2113..2176, exactly DEPTH cycles.
  - done pulses in cycle 2177; IDLE from cycle 2178.
  - busy is high in cycles 1..2177.
- Stall: each in_valid=0 cycle during FILL delays all later events by one cycle.
- Throughput: a new start is accepted in the first IDLE cycle after done.

## Test plan
- Reset, then idle with no start -> every output 0; in_ready stays 0 while in_valid=1.
- Full tile, in_valid always 1, in_data = 16'(L*32+k):
  - row_load[L] is high only in cycle 33*(L+1) for L<32; col_load[L-32] likewise for L≥32.
  - During row_load[3], line_data[5]=101.
  - read_en high in cycles 2113..2176; done in cycle 2177 only.
- Random in_valid gaps (30% low) -> same load order and line contents as the no-gap run; read_en count is exactly 64; no element lost or duplicated.
- start pulsed during FILL, STREAM and DONE -> ignored; exactly one done per accepted start.
- rst_n asserted at line 40, element 10 -> outputs 0 within the cycle. A fresh start then begins at line 0: row_load[0] is the first strobe.
- Back-to-back tiles with start held high -> second tile FILL begins in the cycle after the IDLE cycle that samples start; line_data of the second tile's first LOAD holds the new elements.

Source files
------------

// File: rtl/inject_loader.sv
// Input-path sequencer for the systolic array: builds A-row / B-column lines from a
// serial element stream, strobes each into its staggering FIFO, then drains all FIFOs.
module inject_loader #(
    parameter int DIM    = 32,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [DATA_W-1:0]          in_data_i,
    output logic [0:DIM-1][DATA_W-1:0] line_data_o,
    output logic [DIM-1:0]             row_load_o,
    output logic [DIM-1:0]             col_load_o,
    output logic                       read_en_o,
    output logic                       busy_o,
    output logic                       done_o
);
    localparam int EW = $clog2(DIM);
    localparam int LW = $clog2(2 * DIM);
    localparam int RW = $clog2(DEPTH);

    localparam logic [EW-1:0]  ELEM_LAST = EW'(DIM - 1);
    localparam logic [LW-1:0]  LINE_LAST = LW'(2 * DIM - 1);
    localparam logic [LW-1:0]  LINE_DIM  = LW'(DIM);
    localparam logic [RW-1:0]  RD_LAST   = RW'(DEPTH - 1);
    localparam logic [DIM-1:0] ONE_HOT0  = DIM'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_LOAD,
        S_STREAM,
        S_DONE
    } state_e;

    state_e                     state_q, state_d;
    logic [EW-1:0]              elem_idx_q, elem_idx_d;
    logic [LW-1:0]              line_idx_q, line_idx_d;
    logic [RW-1:0]              rd_cnt_q, rd_cnt_d;
    logic [0:DIM-1][DATA_W-1:0] line_q, line_d;
    logic [LW-1:0]              col_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            elem_idx_q <= '0;
            line_idx_q <= '0;
            rd_cnt_q   <= '0;
            line_q     <= '0;
        end else begin
            state_q    <= state_d;
            elem_idx_q <= elem_idx_d;
            line_idx_q <= line_idx_d;
            rd_cnt_q   <= rd_cnt_d;
            line_q     <= line_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        elem_idx_d = elem_idx_q;
        line_idx_d = line_idx_q;
        rd_cnt_d   = rd_cnt_q;
        line_d     = line_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d    = S_FILL;
                    elem_idx_d = '0;
                    line_idx_d = '0;
                end
            end
            S_FILL: begin
                // in_ready is high throughout FILL, so valid alone means a transfer
                if (in_valid_i) begin
                    line_d[elem_idx_q] = in_data_i;
                    if (elem_idx_q == ELEM_LAST) begin
                        elem_idx_d = '0;
                        state_d    = S_LOAD;
                    end else begin
                        elem_idx_d = elem_idx_q + EW'(1);
                    end
                end
            end
            S_LOAD: begin
                if (line_idx_q == LINE_LAST) begin
                    rd_cnt_d = '0;
                    state_d  = S_STREAM;
                end else begin
                    line_idx_d = line_idx_q + LW'(1);
                    state_d    = S_FILL;
                end
            end
            S_STREAM: begin
                if (rd_cnt_q == RD_LAST) begin
                    state_d = S_DONE;
                end else begin
                    rd_cnt_d = rd_cnt_q + RW'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign col_idx = line_idx_q - LINE_DIM;

    // Strobes depend on registered state only, so FIFOs see a glitch-free load pulse
    always_comb begin
        row_load_o = '0;
        col_load_o = '0;
        if (state_q == S_LOAD) begin
            if (line_idx_q < LINE_DIM) begin
                row_load_o = ONE_HOT0 << line_idx_q;
            end else begin
                col_load_o = ONE_HOT0 << col_idx;
            end
        end
    end

    assign in_ready_o  = (state_q == S_FILL);
    assign read_en_o   = (state_q == S_STREAM);
    assign busy_o      = (state_q != S_IDLE);
    assign done_o      = (state_q == S_DONE);
    assign line_data_o = line_q;

endmodule
